step_pulse_gen: RTL

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pkg.sv | 15 +
 rtl/debounce_filter.sv | 54 +++++
 rtl/step_pulse_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/step_pkg.sv
// Shared definitions for the step/run pulse generator: FSM state encodings
// and default timing constants for a 27 MHz board clock.
package step_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } StepState;

    // 10 ms of stable button level, and a 10 Hz free-run rate, at 27 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 270000;
    localparam int DEF_RUN_DIVIDE      = 2700000;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter for an
// active-low pushbutton; level_n only moves after the input has settled.
module debounce_filter
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_27,
    input  logic reset,
    input  logic raw_n,
    output logic level_n
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_count;
    logic             w_differs;
    logic             w_settled;

    assign w_differs = (r_sync2 != r_level);
    assign w_settled = w_differs && (r_count == CNT_LAST);

    // Released button reads high, so the synchroniser presets to 1
    always_ff @(posedge clk_27) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_27) begin
        if (reset) begin
            r_level <= 1'b1;
            r_count <= '0;
        end else if (!w_differs) begin
            r_count <= '0;
        end else if (w_settled) begin
            r_level <= ~r_level;
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign level_n = r_level;

endmodule

// File: rtl/step_pulse_gen.sv
// Step/run pulse generator: turns a debounced pushbutton or a free-run switch
// into single-cycle step_en pulses for the processor, with a running count.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIVIDE      = DEF_RUN_DIVIDE
) (
    input  logic        clk_27,
    input  logic        reset,
    input  logic        pb_step_n,
    input  logic        run_mode,
    input  logic        hold,
    output logic        step_en,
    output logic [31:0] step_count,
    output logic        pb_level,
    output logic [1:0]  state
);

    localparam int               PRE_W    = $clog2(RUN_DIVIDE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RUN_DIVIDE - 1);

    logic             w_pbLevel;
    logic             w_press;
    logic             r_pbPrev;
    logic             r_runSync1;
    logic             r_runSync2;
    StepState         r_state;
    StepState         w_stateNext;
    logic             r_stepEn;
    logic             w_stepEnNext;
    logic [PRE_W-1:0] r_prescale;
    logic [PRE_W-1:0] w_prescaleNext;
    logic [31:0]      r_stepCount;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pbFilter (
        .clk_27 (clk_27),
        .reset  (reset),
        .raw_n  (pb_step_n),
        .level_n(w_pbLevel)
    );

    // A press is the debounced level falling; releases are ignored
    assign w_press = r_pbPrev && !w_pbLevel;

    always_ff @(posedge clk_27) begin
        if (reset) begin
            r_runSync1 <= 1'b0;
            r_runSync2 <= 1'b0;
            r_pbPrev   <= 1'b1;
        end else begin
            r_runSync1 <= run_mode;
            r_runSync2 <= r_runSync1;
            r_pbPrev   <= w_pbLevel;
        end
    end

    // Priority in every state: hold, then mode change, then press/terminal
    always_comb begin
        w_stateNext    = r_state;
        w_stepEnNext   = 1'b0;
        w_prescaleNext = '0;
        unique case (r_state)
            IDLE: begin
                if (hold) begin
                    w_stateNext = HALT;
                end else if (r_runSync2) begin
                    w_stateNext = RUN;
                end else if (w_press) begin
                    w_stepEnNext = 1'b1;
                end
            end
            RUN: begin
                if (hold) begin
                    w_stateNext = HALT;
                end else if (!r_runSync2) begin
                    w_stateNext = IDLE;
                end else if (r_prescale == PRE_LAST) begin
                    w_stepEnNext = 1'b1;
                end else begin
                    w_prescaleNext = r_prescale + PRE_W'(1);
                end
            end
            HALT: begin
                if (w_press && !hold) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_27) begin
        if (reset) begin
            r_state     <= IDLE;
            r_stepEn    <= 1'b0;
            r_prescale  <= '0;
            r_stepCount <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_stepEn   <= w_stepEnNext;
            r_prescale <= w_prescaleNext;
            if (w_stepEnNext) begin
                r_stepCount <= r_stepCount + 32'd1;
            end
        end
    end

    assign step_en    = r_stepEn;
    assign step_count = r_stepCount;
    assign pb_level   = w_pbLevel;
    assign state      = r_state;

endmodule
